decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Receiving end of the fetch-stage valid/allowin handshake. Buffers {pc, inst} pairs that
//  fetch presents and hands them to decode through the same valid/allowin protocol.
//  allowin is registered-state only, so decode back-pressure never reaches fetch
//  combinationally. A branch-redirect flush discards every buffered entry in one cycle.
// PARAMETERS
//  DEPTH       2   number of entries; power of two, >= 2
//  PTR_W       1   log2(DEPTH); the instantiating module sets it consistently with DEPTH
// PORTS
//  clk           in   1      rising-edge clock
//  resetn        in   1      asynchronous, active-low reset
//  pre_valid     in   1      fetch has a valid {in_pc,in_inst} (fetch goon_valid)
//  cur_allowin   out  1      queue accepts an entry this cycle (to fetch post_allowin)
//  in_pc         in   32     PC of the incoming instruction
//  in_inst       in   32     incoming instruction word
//  flush         in   1      redirect: discard all entries, ignore this cycle's input
//  cur_stall     in   1      hold the head entry; suppresses goon_valid
//  goon_valid    out  1      head entry valid toward decode
//  post_allowin  in   1      decode accepts the head entry this cycle
//  out_pc        out  32     PC of the head entry
//  out_inst      out  32     instruction word of the head entry
//  count         out  PTR_W+1  number of occupied entries, 0..DEPTH
// BEHAVIOUR
//  Reset (resetn=0, async): count=0, wr_ptr=rd_ptr=0, all storage=0.
//   Outputs during reset: cur_allowin=1, goon_valid=0, out_pc=0, out_inst=0.
//  cur_allowin = (count != DEPTH). It depends only on registered state: no path from
//   post_allowin, cur_stall or flush.
//  push = pre_valid & cur_allowin & !flush. On push, mem[wr_ptr] <= {in_pc,in_inst} and
//   wr_ptr increments, wrapping modulo DEPTH.
//  goon_valid = (count != 0) & !cur_stall & !flush.
//  pop = goon_valid & post_allowin. On pop, rd_ptr increments, wrapping modulo DEPTH.
//  out_pc/out_inst = mem[rd_ptr], driven combinationally from storage.
//   They are stable while goon_valid=1 and pop=0.
//  count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
//  Latency: an entry pushed at edge N is visible with goon_valid=1 in the cycle after
//   edge N (1 cycle). There is no same-cycle bypass, and empty never forwards in_* directly.
//  Full (count==DEPTH): cur_allowin=0, so fetch holds. A pop in that cycle does NOT
//   enable a same-cycle push; allowin rises the following cycle.
//  Empty (count==0): goon_valid=0 regardless of post_allowin. out_* show stale mem[rd_ptr].
//  Flush has priority over everything. At the next edge count=0 and wr_ptr=rd_ptr=0.
//   The push and pop of the flush cycle are both cancelled (goon_valid forced 0).
//   Storage contents are not cleared.
//  cur_stall: while asserted, goon_valid=0 and no pop. Pushes continue until full.
//  Reset assertion mid-operation drops all entries immediately (async). Operation resumes
//   at the first clk edge after resetn rises.
//  Only the head-entry read mux and the pointer/count registers exist. There are no
//   other state machines: the FSM is implicit in count (EMPTY / PARTIAL / FULL).
// STRUCTURE
//  defines.h (shared, existing): `RESET_PC, data-width macros; add `DQ_DEPTH default.
//  Storage is an internal reg array; pointer/count logic is inline.
//  No sub-module is natural. If the storage is ever reused, extract it as dq_entry_ram
//   (1W/1R, async read).
// TESTING
//  1 Reset: resetn=0 mid-stream with count=2 -> next cycle count=0, goon_valid=0,
//    cur_allowin=1, out_pc=0.
//  2 Fill: push pc 0xBFC00000, 0xBFC00004 with post_allowin=0 -> count=2, cur_allowin=0.
//    Third pre_valid is not accepted, and out_pc stays 0xBFC00000.
//  3 Full+pop: from count=2, post_allowin=1 for 1 cycle with pre_valid=1 -> count=1,
//    no push that cycle. Next cycle push occurs -> count=2, out_pc=0xBFC00004.
//  4 Streaming: pre_valid=post_allowin=1 for 8 cycles, pcs 0x00..0x1C -> count steady at 1.
//    Decode sees all 8 in order, one per cycle after 1-cycle latency, including pointer wrap.
//  5 Flush: count=2, flush=1 together with pre_valid=1 and post_allowin=1 -> goon_valid=0
//    that cycle. Next cycle count=0 and no entry was consumed or added.
//  6 Stall: count=1, cur_stall=1 and post_allowin=1 for 3 cycles -> goon_valid=0, no pop,
//    out_pc held. Release -> popped in the first cycle with cur_stall=0.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared widths and the {pc, inst} entry payload for the fetch-to-decode queue.
package decode_queue_pkg;

  localparam int unsigned DQ_DATA_W = 32;
  localparam int unsigned DQ_DEPTH  = 2;
  localparam int unsigned DQ_PTR_W  = $clog2(DQ_DEPTH);

  typedef struct packed {
    logic [DQ_DATA_W-1:0] pc;
    logic [DQ_DATA_W-1:0] inst;
  } dq_entry_t;

endpackage

// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue: valid/allowin handshake on both sides,
// allowin from registered occupancy only, single-cycle flush of all entries.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DQ_DEPTH,
  parameter int unsigned PTR_W = DQ_PTR_W
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pre_valid,
  output logic                 cur_allowin,
  input  logic [DQ_DATA_W-1:0] in_pc,
  input  logic [DQ_DATA_W-1:0] in_inst,
  input  logic                 flush,
  input  logic                 cur_stall,
  output logic                 goon_valid,
  input  logic                 post_allowin,
  output logic [DQ_DATA_W-1:0] out_pc,
  output logic [DQ_DATA_W-1:0] out_inst,
  output logic [PTR_W:0]       count
);

  dq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_count_next;
  dq_entry_t        w_head;

  // Handshake decode; allowin sees only r_count so decode stalls never reach fetch.
  always_comb begin
    cur_allowin  = (r_count != (PTR_W+1)'(DEPTH));
    goon_valid   = (r_count != '0) & ~cur_stall & ~flush;
    w_push       = pre_valid & cur_allowin & ~flush;
    w_pop        = goon_valid & post_allowin;
    w_count_next = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    w_head       = r_mem[r_rd_ptr];
  end

  assign out_pc   = w_head.pc;
  assign out_inst = w_head.inst;
  assign count    = r_count;

  // Pointers, occupancy and storage; flush rewinds pointers but leaves data in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{pc: in_pc, inst: in_inst};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed table-driven bench for decode_queue plus a hand-written async-reset sequence.
module tb_decode_queue;

  logic        clk;
  logic        resetn;
  logic        pre_valid;
  logic        cur_allowin;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        cur_stall;
  logic        goon_valid;
  logic        post_allowin;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  count;

  int n_tests;
  int n_fail;

  localparam logic [31:0] INST_KEY = 32'h0F0F_0F0F;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        st;
    logic        pa;
    logic [1:0]  e_cnt;
    logic        e_alw;
    logic        e_gv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  decode_queue #(.DEPTH(2), .PTR_W(1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pre_valid    (pre_valid),
    .cur_allowin  (cur_allowin),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .flush        (flush),
    .cur_stall    (cur_stall),
    .goon_valid   (goon_valid),
    .post_allowin (post_allowin),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic pv, input logic [31:0] pc, input logic fl, input logic st,
                     input logic pa, input logic [1:0] cnt, input logic alw, input logic gv,
                     input logic [31:0] opc);
    vec_t v;
    v.pv = pv; v.pc = pc; v.fl = fl; v.st = st; v.pa = pa;
    v.e_cnt = cnt; v.e_alw = alw; v.e_gv = gv; v.e_pc = opc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic fl,
                       input logic st, input logic pa);
    pre_valid    = pv;
    in_pc        = pc;
    in_inst      = pc ^ INST_KEY;
    flush        = fl;
    cur_stall    = st;
    post_allowin = pa;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    //  pv  pc            fl    st    pa    cnt   alw   gv    out_pc
    // Fill to full; third offer refused, head unchanged
    add(1, 32'hBFC00000, 0, 0, 0, 2'd0, 1, 0, 32'h00000000);
    add(1, 32'hBFC00004, 0, 0, 0, 2'd1, 1, 1, 32'hBFC00000);
    add(1, 32'hBFC00008, 0, 0, 0, 2'd2, 0, 1, 32'hBFC00000);
    // Pop while full: no same-cycle push; push lands next cycle
    add(1, 32'hBFC00008, 0, 0, 1, 2'd2, 0, 1, 32'hBFC00000);
    add(1, 32'hBFC00008, 0, 0, 0, 2'd1, 1, 1, 32'hBFC00004);
    add(0, 32'h0,        0, 0, 0, 2'd2, 0, 1, 32'hBFC00004);
    // Drain, then empty shows stale head
    add(0, 32'h0,        0, 0, 1, 2'd2, 0, 1, 32'hBFC00004);
    add(0, 32'h0,        0, 0, 1, 2'd1, 1, 1, 32'hBFC00008);
    add(0, 32'h0,        0, 0, 0, 2'd0, 1, 0, 32'hBFC00004);
    // Streaming 0x00..0x1C, one-cycle latency, pointer wrap
    add(1, 32'h00,       0, 0, 1, 2'd0, 1, 0, 32'hBFC00004);
    for (int k = 1; k < 8; k++) begin
      add(1, 32'(4*k), 0, 0, 1, 2'd1, 1, 1, 32'(4*(k-1)));
    end
    add(0, 32'h0,        0, 0, 1, 2'd1, 1, 1, 32'h1C);
    // Flush with push and pop requested
    add(1, 32'h100,      0, 0, 0, 2'd0, 1, 0, 32'h18);
    add(1, 32'h104,      0, 0, 0, 2'd1, 1, 1, 32'h100);
    add(1, 32'h108,      1, 0, 1, 2'd2, 0, 0, 32'h100);
    add(0, 32'h0,        0, 0, 0, 2'd0, 1, 0, 32'h104);
    // Stall holds the head for three cycles, pops on release
    add(1, 32'h200,      0, 0, 0, 2'd0, 1, 0, 32'h104);
    add(0, 32'h0,        0, 1, 1, 2'd1, 1, 0, 32'h200);
    add(0, 32'h0,        0, 1, 1, 2'd1, 1, 0, 32'h200);
    add(0, 32'h0,        0, 1, 1, 2'd1, 1, 0, 32'h200);
    add(0, 32'h0,        0, 0, 1, 2'd1, 1, 1, 32'h200);
    add(0, 32'h0,        0, 0, 0, 2'd0, 1, 0, 32'h100);

    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_allowin", 32'(cur_allowin), 32'd1);
    chk("rst_goon", 32'(goon_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].pc, vecs[i].fl, vecs[i].st, vecs[i].pa);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_allowin", i), 32'(cur_allowin), 32'(vecs[i].e_alw));
      chk($sformatf("v%0d_goon", i), 32'(goon_valid), 32'(vecs[i].e_gv));
      chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
      if (vecs[i].e_gv) begin
        chk($sformatf("v%0d_out_inst", i), out_inst, vecs[i].e_pc ^ INST_KEY);
      end
    end

    // Async reset mid-stream with two entries held
    @(negedge clk);
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_count", 32'(count), 32'd2);
    chk("pre_rst_out_pc", out_pc, 32'h300);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_goon", 32'(goon_valid), 32'd0);
    chk("arst_allowin", 32'(cur_allowin), 32'd1);
    chk("arst_out_pc", out_pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("resume_count", 32'(count), 32'd1);
    chk("resume_goon", 32'(goon_valid), 32'd1);
    chk("resume_out_pc", out_pc, 32'h400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
